lhca_word_packer: RTL and testbench

- Downstream consumer of the 8-bit LHCA pseudo-random state register.
- Accepts one LHCA byte per cycle on a valid/ready handshake and packs BYTES bytes little-endian into one wide word.
- Presents the word on a valid/ready output with a one-entry output register.
- Back-pressure is returned to the LHCA stage via in_ready, which gates the LHCA clock enable.

---
 rtl/lhca_pkg.sv | 17 +
 rtl/lhca_health_mon.sv | 43 ++++
 rtl/lhca_word_packer.sv | 88 ++++++++
 tb/tb_lhca_word_packer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lhca_pkg.sv
// lhca_pkg -- shared constants and types for the LHCA byte packer.
//   LHCA_W       : width of one LHCA state byte
//   lhca_byte_t  : one LHCA state byte
//   BYTES_DEF    : default number of bytes packed per word
//   idx_w()      : width of the byte-index register for a given BYTES
package lhca_pkg;

  localparam int LHCA_W    = 8;
  localparam int BYTES_DEF = 4;

  typedef logic [LHCA_W-1:0] lhca_byte_t;

  function automatic int idx_w(input int bytes);
    return (bytes < 2) ? 1 : $clog2(bytes);
  endfunction

endpackage

// File: rtl/lhca_health_mon.sv
// lhca_health_mon -- watches accepted LHCA bytes for signs of a broken generator.
// A maximal-length LHCA never emits 0x00 and never repeats a state on
// consecutive steps; either event sets a sticky error.
//   clk, rst_n : clock, async active-low reset
//   i_vld      : i_byte accepted this cycle
//   i_byte     : accepted byte
//   o_err      : sticky health failure, asserts the cycle after the bad byte
module lhca_health_mon
  import lhca_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_vld,
  input  lhca_byte_t i_byte,
  output logic       o_err
);

  lhca_byte_t r_prev;
  logic       r_prev_vld;
  logic       r_err;
  logic       w_bad;

  // r_prev_vld keeps the first byte after reset from being compared
  // against the reset value of r_prev.
  assign w_bad = i_vld & ((i_byte == '0) | (r_prev_vld & (i_byte == r_prev)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (i_vld) begin
        r_prev     <= i_byte;
        r_prev_vld <= 1'b1;
      end
      if (w_bad) r_err <= 1'b1;
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/lhca_word_packer.sv
// lhca_word_packer -- packs BYTES LHCA bytes little-endian into one word.
// Optional health monitor enabled by defining LHCA_PACKER_HEALTH_EN.
//   CLK, RESETN          : clock, async active-low reset
//   in_data/valid/ready  : byte input handshake (in_ready gates the LHCA enable)
//   out_data/valid/ready : packed word output, one-entry register
//   word_cnt             : words handed off, wraps
//   health_err           : sticky LHCA health failure (0 without the monitor)
module lhca_word_packer
  import lhca_pkg::*;
#(
  parameter int BYTES = BYTES_DEF,
  parameter int CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [LHCA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [LHCA_W*BYTES-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      word_cnt,
  output logic                  health_err
);

  localparam int IDX_W = idx_w(BYTES);

  // Only the first BYTES-1 lanes need storage; the final byte goes
  // straight from in_data into the output register.
  logic [BYTES-2:0][LHCA_W-1:0] r_acc;
  logic [IDX_W-1:0]             r_idx;
  logic [LHCA_W*BYTES-1:0]      r_out;
  logic                         r_out_vld;
  logic [CNT_W-1:0]             r_cnt;

  logic w_last, w_acc, w_load, w_hoff;

  assign w_last = (r_idx == IDX_W'(BYTES-1));
  // Non-final bytes never stall; the final byte needs a free (or draining)
  // output register.
  assign in_ready = ~w_last | ~r_out_vld | out_ready;
  assign w_acc    = in_valid & in_ready;
  assign w_load   = w_acc & w_last;
  assign w_hoff   = r_out_vld & out_ready;

  for (genvar g = 0; g < BYTES-1; g++) begin : g_lane
    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN)                            r_acc[g] <= '0;
      else if (w_acc && r_idx == IDX_W'(g))   r_acc[g] <= in_data;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_idx     <= '0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_acc) r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      // A load on the handoff edge wins, keeping out_valid high.
      if (w_load) begin
        r_out     <= {in_data, r_acc};
        r_out_vld <= 1'b1;
      end else if (w_hoff) begin
        r_out_vld <= 1'b0;
      end
      if (w_hoff) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_data  = r_out;
  assign out_valid = r_out_vld;
  assign word_cnt  = r_cnt;

`ifdef LHCA_PACKER_HEALTH_EN
  lhca_health_mon u_health (
    .clk    (CLK),
    .rst_n  (RESETN),
    .i_vld  (w_acc),
    .i_byte (in_data),
    .o_err  (health_err)
  );
`else
  assign health_err = 1'b0;
`endif

endmodule

// File: tb/tb_lhca_word_packer.sv
module tb_lhca_word_packer;

  localparam int BYTES = 4;
  localparam int CNT_W = 4;
  localparam int CMOD  = 1 << CNT_W;
  localparam int WW    = 8 * BYTES;

  logic              CLK = 1'b0;
  logic              RESETN = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  word_cnt;
  logic              health_err;

  lhca_word_packer #(.BYTES(BYTES), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .word_cnt(word_cnt), .health_err(health_err)
  );

  always #5 CLK = ~CLK;

  // ---- reference model state ----
  logic [WW-1:0] exp_q[$];     // words whose last byte was accepted, not yet handed off
  logic [7:0]    bq[$];        // bytes of the word being assembled
  int            cnt_model = 0;
  int            pushed    = 0; // word completed in the current cycle (not yet in DUT)
  logic          m_err = 0, m_err_nxt = 0;
  logic [7:0]    m_prev = '0;
  logic          m_prev_v = 0;
  logic          started = 0;

  int vec  = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete(); bq.delete();
    cnt_model = 0; pushed = 0;
    m_err = 0; m_err_nxt = 0; m_prev = '0; m_prev_v = 0;
  endfunction

  function automatic void model_accept(input logic [7:0] d);
    logic [WW-1:0] w;
`ifdef LHCA_PACKER_HEALTH_EN
    if (d == 8'h00 || (m_prev_v && d == m_prev)) m_err_nxt = 1'b1;
`endif
    m_prev = d; m_prev_v = 1'b1;
    bq.push_back(d);
    if (bq.size() == BYTES) begin
      w = '0;
      foreach (bq[i]) w = w | (WW'(bq[i]) << (8 * i));
      exp_q.push_back(w);
      bq.delete();
      pushed = 1;
    end
  endfunction

  // One clock cycle of stimulus; returns whether the byte was taken.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r, output logic took);
    logic exp_rdy;
    @(posedge CLK); #1;
    m_err = m_err_nxt; pushed = 0;
    in_valid = v; in_data = d; out_ready = r;
    #2;
    exp_rdy = (bq.size() != BYTES-1) || (exp_q.size() == 0) || r;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    took = v && in_ready;
    if (took) model_accept(d);
  endtask

  task automatic send(input logic [7:0] d, input logic r);
    logic took;
    for (int n = 0; n < 40; n++) begin
      cyc(1'b1, d, r, took);
      if (took) return;
    end
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    logic took;
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b1, took);
  endtask

  // Reset asserted between edges; outputs must clear immediately.
  task automatic do_reset();
    #1;
    RESETN = 1'b0; in_valid = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    chk("rst_health", 64'(health_err), 64'd0);
    @(posedge CLK); #2;
    RESETN = 1'b1;
  endtask

  // ---- monitor / scoreboard ----
  initial begin
    logic [WW-1:0] w;
    int            live;
    forever begin
      @(negedge CLK);
      if (started && RESETN) begin
        live = exp_q.size() - pushed;
        chk("out_valid", 64'(out_valid), 64'(live > 0));
        chk("health_err", 64'(health_err), 64'(m_err));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'(out_data), 64'd0);
          end else begin
            w = exp_q.pop_front();
            chk("out_data", 64'(out_data), 64'(w));
            chk("word_cnt", 64'(word_cnt), 64'(cnt_model % CMOD));
            cnt_model++;
          end
        end
      end
    end
  end

  initial begin
    logic took;
    logic [7:0] d;
    repeat (3) @(posedge CLK);
    #3;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_word_cnt", 64'(word_cnt), 64'd0);
    chk("reset_health", 64'(health_err), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge CLK); #2;
    RESETN = 1'b1;
    started = 1'b1;

    // streaming, out_ready held high
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b1);
    idle(2);
    chk("stream_cnt", 64'(word_cnt), 64'd2);

    // back-pressure: word held, final byte refused until drained
    for (int i = 8'h11; i <= 8'h14; i++) send(8'(i), 1'b0);
    for (int i = 8'h15; i <= 8'h17; i++) send(8'(i), 1'b0);
    cyc(1'b1, 8'h18, 1'b0, took);
    chk("bp_refused", 64'(took), 64'd0);
    chk("bp_held_data", 64'(out_data), 64'h14131211);
    cyc(1'b1, 8'h18, 1'b1, took);   // handoff and load on the same edge
    chk("bp_took", 64'(took), 64'd1);
    cyc(1'b1, 8'hA1, 1'b0, took);
    chk("bp_new_word", 64'(out_data), 64'h18171615);
    chk("bp_still_valid", 64'(out_valid), 64'd1);

    // reset mid-word with a stalled word in the output register
    send(8'hA2, 1'b0);
    do_reset();
    for (int i = 8'h11; i <= 8'h14; i++) send(8'(i), 1'b1);
    cyc(1'b0, 8'h00, 1'b1, took);
    chk("post_rst_word", 64'(out_data), 64'h14131211);
    idle(1);

    // health patterns
    do_reset();
    send(8'h00, 1'b1); send(8'h31, 1'b1); send(8'h32, 1'b1); send(8'h33, 1'b1);
    idle(2);
`ifdef LHCA_PACKER_HEALTH_EN
    chk("health_zero", 64'(health_err), 64'd1);
`else
    chk("health_zero_off", 64'(health_err), 64'd0);
`endif
    do_reset();
    send(8'h5A, 1'b1); send(8'h5A, 1'b1); idle(2);
    do_reset();
    send(8'h5A, 1'b1); send(8'h5B, 1'b1); idle(2);
    chk("health_distinct", 64'(health_err), 64'd0);

    // counter wrap: 17 words
    do_reset();
    for (int i = 0; i < 17 * BYTES; i++) send(8'(i + 1), 1'b1);
    idle(2);
    chk("wrap_cnt", 64'(word_cnt), 64'd1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      d = 8'($urandom_range(255));
      cyc(1'($urandom_range(99) < 70), d, 1'($urandom_range(99) < 60), took);
    end
    idle(3);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
